// File: rtl/program_counter.sv
// Fetch-stage program counter: registers the externally computed next address every cycle.
// Optional hold input `stall` is compiled in when PC_STALL_EN is defined.
module program_counter #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PC_STALL_EN
  input  logic              stall,
`endif
  input  logic [ADDR_W-1:0] next_address,
  output logic [ADDR_W-1:0] address
);

  // Stored verbatim: no alignment, increment or wrap handling lives here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address <= RESET_ADDR;
`ifdef PC_STALL_EN
    end else if (!stall) begin
      address <= next_address;
`else
    end else begin
      address <= next_address;
`endif
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver queues expected addresses,
// and the monitor compares one entry on each falling clock edge.
module tb_program_counter;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] next_address = 16'h0AAA;
  logic [15:0] address;
`ifdef PC_STALL_EN
  logic        stall = 1'b0;
`endif

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  program_counter #(.ADDR_W(16), .RESET_ADDR(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PC_STALL_EN
    .stall        (stall),
`endif
    .next_address (next_address),
    .address      (address)
  );

  // Inputs change 2 time units after the rising edge; the monitor samples
  // at the falling edge, so an async reset applied here is seen before the next rising edge.
  task automatic step(input logic r, input logic [15:0] nxt, input logic [15:0] exp,
                      input string name);
    exp_t e;
    @(posedge clk);
    #2;
    rst          = r;
    next_address = nxt;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

`ifdef PC_STALL_EN
  task automatic sstep(input logic r, input logic s, input logic [15:0] nxt,
                       input logic [15:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #2;
    rst          = r;
    stall        = s;
    next_address = nxt;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask
`endif

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (address !== e.exp) begin
        failures++;
        $display("FAIL %s: address=%h required=%h", e.name, address, e.exp);
      end
    end
  end

  initial begin
    // First edge loads 0x0AAA so the following reset has something to clear.
    step(1'b1, 16'h0AAA, 16'h0AAA, "preload");
    step(1'b0, 16'h0000, 16'h0000, "rst_assert_async");
    step(1'b1, 16'h0002, 16'h0000, "rst_release_no_change");

    for (int i = 1; i <= 14; i++)
      step(1'b1, 16'((i + 1) * 2), 16'(i * 2), $sformatf("fetch_%0d", i));

    step(1'b0, 16'h001E, 16'h0000, "midrun_rst_async");
    step(1'b1, 16'h0002, 16'h0000, "midrun_release");
    step(1'b1, 16'h0004, 16'h0002, "resume_0002");
    step(1'b1, 16'h1234, 16'h0004, "resume_0004");

    step(1'b0, 16'h1234, 16'h0000, "held_rst_enter");
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h1234, 16'h0000, $sformatf("held_rst_%0d", i));
    step(1'b1, 16'hFFFE, 16'h0000, "held_rst_release");

    step(1'b1, 16'h0000, 16'hFFFE, "load_fffe");
    step(1'b1, 16'h0003, 16'h0000, "wrap_0000");
    step(1'b1, 16'h5A5A, 16'h0003, "odd_lsb_0003");
    step(1'b1, 16'hA5A5, 16'h5A5A, "load_5a5a");
    step(1'b1, 16'h0010, 16'hA5A5, "load_a5a5");

`ifdef PC_STALL_EN
    sstep(1'b1, 1'b0, 16'h0012, 16'h0010, "load_0010");
    sstep(1'b1, 1'b1, 16'h0012, 16'h0012, "load_0012_then_stall");
    sstep(1'b1, 1'b1, 16'h0014, 16'h0012, "stall_hold_1");
    sstep(1'b1, 1'b0, 16'h0014, 16'h0012, "stall_hold_2");
    sstep(1'b1, 1'b1, 16'h0016, 16'h0014, "stall_release_load");
    sstep(1'b0, 1'b1, 16'h0016, 16'h0000, "rst_during_stall");
    sstep(1'b1, 1'b1, 16'h0018, 16'h0000, "rst_stall_release");
    sstep(1'b1, 1'b0, 16'h0018, 16'h0000, "stall_after_rst");
    sstep(1'b1, 1'b0, 16'h001A, 16'h0018, "unstalled_load");
`else
    step(1'b1, 16'h0012, 16'h0010, "load_0010");
    step(1'b1, 16'h0012, 16'h0012, "load_0012");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program counter register for the pipelined datapath's fetch stage.
- Holds the current instruction address and drives it to instruction memory and the PC-increment/branch logic.
- Captures the externally computed next address (PC+2, branch or jump target) on every rising clock edge.
- Asynchronous active-low reset forces the reset vector.

Parameters:
- ADDR_W, 16, width of the address path in bits.
- RESET_ADDR, 16'h0000, value loaded into address while reset is asserted; must fit in ADDR_W bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge except reset.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- next_address  input  ADDR_W  address to load on the next rising clk edge.
- address  output  ADDR_W  current PC value; registered output, no combinational path from next_address.

Interface decision (fixed): one clock, clk; reset port rst is asynchronous and active-low.

Behaviour:
- Reset value:
  - rst falling to 0 sets address = RESET_ADDR immediately, without waiting for a clock edge.
  - address stays at RESET_ADDR for as long as rst = 0, regardless of clk or next_address activity.
- Reset release:
  - rst rising to 1 does not change address.
  - The first rising clk edge with rst = 1 loads next_address.
  - Reset release coinciding with a clk edge: that edge does not load; loading begins on the next edge.
- Normal operation:
  - On each rising clk edge with rst = 1: address <= next_address.
  - Latency is one cycle from next_address to address.
  - No enable, no internal increment, no internal alignment forcing. The value is stored verbatim, including an odd LSB.
- Arithmetic: none internal. Wrap-around (0xFFFE + 2 = 0x0000) is the caller's responsibility; the block stores whatever value arrives.
- Reset mid-operation: takes effect asynchronously at any phase of clk and overrides any load on that edge.
- X/Z on next_address: propagated into address on the capture edge; no filtering.
- Power-up: address is undefined until the first reset assertion. The system must assert rst at start-up.

Optional Feature:
- Macro: PC_STALL_EN.
- When defined:
  - Adds input port stall (1 bit, active-high), placed after rst.
  - On a rising clk edge with rst = 1 and stall = 1, address holds its value.
  - With stall = 0 the block behaves as in base operation.
  - Reset overrides stall.
- When undefined:
  - Port stall does not exist.
  - address loads every cycle exactly as in Behaviour.

Test Plan:
1. Reset assert/release: hold rst = 1 with next_address = 0x0000, drive rst = 0 between clock edges -> address = 0x0000 immediately. Raise rst = 1 -> address stays 0x0000 until the next edge.
2. Sequential fetch: after release, drive next_address = address + 2 each cycle for 14 cycles -> address steps 0x0002, 0x0004, … 0x001C, one step per rising edge.
3. Mid-run reset: with address = 0x001C, pulse rst low for one cycle between edges -> address = 0x0000 asynchronously. Incrementing resumes from 0x0002 after release.
4. Held reset: rst = 0 across 3 rising edges with next_address = 0x1234 -> address stays 0x0000.
5. Wrap and verbatim load: load 0xFFFE, then next_address = 0x0000 -> address 0xFFFE then 0x0000. Load 0x0003 -> address = 0x0003 (no alignment).
6. (PC_STALL_EN) address = 0x0010, stall = 1 for 2 edges with next_address = 0x0012 -> address stays 0x0010. Drop stall -> 0x0012 on the next edge. rst = 0 during stall -> 0x0000.
